matmul_core: RTL and testbench

Parametrised matrix-multiply engine computing C = A·B for an X×Y matrix A and a Y×Z matrix B held in a shared data memory. It writes the X×Z result matrix C back to the same memory. It replaces the microcoded multiply loop driven through the processor bus with a dedicated FSM, address generator and multiply-accumulate unit. It sits beside the processor on the data-memory port and is started by a single command pulse.

---
 rtl/matmul_core.sv | 202 ++++++++++++++++++++
 tb/tb_matmul_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_core.sv
// rtl/matmul_core.sv - matrix-multiply engine C = A*B over a shared data memory
//
// Purpose: sequences reads of A and B, multiply-accumulates each dot product
// and writes every C element back to memory, row-major, with add-only
// address generation.
//
// Ports:
//   clock, rst_r           clock and asynchronous active-high reset
//   start                  command strobe, honoured only when idle
//   dim_x, dim_y, dim_z    matrix dimensions (A is X*Y, B is Y*Z)
//   base_a, base_b, base_c row-major base addresses of A, B and C
//   rd_en, rd_addr         memory read request; rd_data returns one cycle later
//   wr_en, wr_addr, wr_data registered C element write
//   busy, done             operation in progress / one-cycle completion pulse
//   err                    last accepted command had a zero dimension
//   ovf                    sticky accumulator saturation flag
//
// Build option: MATMUL_SATURATE_EN makes the accumulator saturate and drive
// ovf; without it the accumulator wraps and ovf is tied low.

module matmul_core #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clock,
  input  logic              rst_r,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_x,
  input  logic [DIM_W-1:0]  dim_y,
  input  logic [DIM_W-1:0]  dim_z,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  typedef enum logic [2:0] {IDLE, RA, RB, MAC, WR, FIN} state_t;
  state_t state_q, state_d;

  logic [DIM_W-1:0]    dim_x_q, dim_y_q, dim_z_q;
  logic [DIM_W-1:0]    i_q, j_q, k_q;
  logic [ADDR_W-1:0]   a_row_q, a_ptr_q, b_col_q, b_ptr_q, c_ptr_q, base_b_q;
  logic [DATA_W-1:0]   a_reg_q;
  logic [ACC_W-1:0]    acc_q;
  logic                err_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ACC_W-1:0]    wr_data_q;

  logic                zero_dim, last_i, last_j, last_k, accept;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext, acc_sum;
  logic [ADDR_W-1:0]   y_ext, z_ext;

  assign zero_dim = (dim_x == '0) || (dim_y == '0) || (dim_z == '0);
  assign accept   = (state_q == IDLE) && start;
  assign last_i   = (i_q == dim_x_q - 1'b1);
  assign last_j   = (j_q == dim_y_q - 1'b1);
  assign last_k   = (k_q == dim_z_q - 1'b1);
  assign y_ext    = ADDR_W'(dim_y_q);
  assign z_ext    = ADDR_W'(dim_z_q);

  // Full-width product, zero-extended before it meets the accumulator.
  assign prod     = {{DATA_W{1'b0}}, a_reg_q} * {{DATA_W{1'b0}}, rd_data};
  assign prod_ext = ACC_W'(prod);

`ifdef MATMUL_SATURATE_EN
  logic [ACC_W:0] sum_wide;
  logic           sat;
  logic           ovf_q;

  assign sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
  assign sat      = sum_wide[ACC_W];
  assign acc_sum  = sat ? '1 : sum_wide[ACC_W-1:0];

  always_ff @(posedge clock or posedge rst_r) begin
    if (rst_r)                        ovf_q <= 1'b0;
    else if (accept)                  ovf_q <= 1'b0;
    else if (state_q == MAC && sat)   ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  assign acc_sum = acc_q + prod_ext;
  assign ovf     = 1'b0;
`endif

  always_ff @(posedge clock or posedge rst_r) begin
    if (rst_r) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = zero_dim ? FIN : RA;
      RA:   state_d = RB;
      RB:   state_d = MAC;
      MAC:  state_d = last_j ? WR : RA;
      WR:   state_d = (last_k && last_i) ? FIN : RA;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst_r) begin
    if (rst_r) begin
      dim_x_q   <= '0;
      dim_y_q   <= '0;
      dim_z_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      a_row_q   <= '0;
      a_ptr_q   <= '0;
      b_col_q   <= '0;
      b_ptr_q   <= '0;
      c_ptr_q   <= '0;
      base_b_q  <= '0;
      a_reg_q   <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          dim_x_q  <= dim_x;
          dim_y_q  <= dim_y;
          dim_z_q  <= dim_z;
          err_q    <= zero_dim;
          i_q      <= '0;
          j_q      <= '0;
          k_q      <= '0;
          acc_q    <= '0;
          a_row_q  <= base_a;
          a_ptr_q  <= base_a;
          base_b_q <= base_b;
          b_col_q  <= base_b;
          b_ptr_q  <= base_b;
          c_ptr_q  <= base_c;
        end
        RB: a_reg_q <= rd_data;
        MAC: begin
          acc_q <= acc_sum;
          if (last_j) begin
            // Load the write port now so the WR cycle drives it from flops.
            wr_en_q   <= 1'b1;
            wr_addr_q <= c_ptr_q;
            wr_data_q <= acc_sum;
          end else begin
            j_q     <= j_q + 1'b1;
            a_ptr_q <= a_ptr_q + 1'b1;
            b_ptr_q <= b_ptr_q + z_ext;
          end
        end
        WR: begin
          c_ptr_q <= c_ptr_q + 1'b1;
          acc_q   <= '0;
          j_q     <= '0;
          if (!last_k) begin
            // Next column of B: restart the same row of A.
            k_q     <= k_q + 1'b1;
            a_ptr_q <= a_row_q;
            b_col_q <= b_col_q + 1'b1;
            b_ptr_q <= b_col_q + 1'b1;
          end else if (!last_i) begin
            i_q     <= i_q + 1'b1;
            k_q     <= '0;
            a_row_q <= a_row_q + y_ext;
            a_ptr_q <= a_row_q + y_ext;
            b_col_q <= base_b_q;
            b_ptr_q <= base_b_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en   = (state_q == RA) || (state_q == RB);
  assign rd_addr = (state_q == RB) ? b_ptr_q : a_ptr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign err     = err_q;

endmodule

// File: tb/tb_matmul_core.sv
// tb/tb_matmul_core.sv - self-checking bench for matmul_core against a behavioural matrix model

module tb_matmul_core;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int CW = 16;
  localparam int MW = 8;

  logic          clock = 1'b0;
  logic          rst_r;
  logic          start;
  logic [MW-1:0] dim_x, dim_y, dim_z;
  logic [AW-1:0] base_a, base_b, base_c;
  logic          rd_en, wr_en, busy, done, err, ovf;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] wr_data;

  matmul_core #(.DATA_W(DW), .ACC_W(CW), .ADDR_W(AW), .DIM_W(MW)) dut (
    .clock(clock), .rst_r(rst_r), .start(start),
    .dim_x(dim_x), .dim_y(dim_y), .dim_z(dim_z),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clock = ~clock;

  // Memory and bus monitor: outputs are sampled on the falling edge.
  logic [DW-1:0] mem [0:65535];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_pend_addr = '0;
  logic [AW-1:0] wq_addr [$];
  logic [CW-1:0] wq_data [$];
  int            rd_cnt = 0;
  int            conflicts = 0;

  always @(negedge clock) begin
    rd_pend      <= rd_en;
    rd_pend_addr <= rd_addr;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (rd_en && wr_en) conflicts <= conflicts + 1;
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  always @(posedge clock) begin
    if (rd_pend) rd_data <= mem[rd_pend_addr];
  end

  int errors = 0;
  int checks = 0;
  int a_v [16];
  int b_v [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full command: load memory, predict C, issue start, then check latency,
  // write sequence, read count and flags.
  task automatic run(input int x, input int y, input int z,
                     input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW-1:0] bc,
                     input bit rnd, input bit dbl, input string tag);
    logic [AW-1:0] ea [$];
    logic [CW-1:0] ed [$];
    logic [AW-1:0] ad;
    longint total;
    bit     eovf;
    int     cyc, w0, r0, nexp;
    eovf = 0;
    if (rnd) begin
      for (int n = 0; n < 16; n++) begin
        a_v[n] = $urandom_range(0, 255);
        b_v[n] = $urandom_range(0, 255);
      end
    end
    for (int i = 0; i < x; i++)
      for (int j = 0; j < y; j++) begin
        ad = ba + AW'(i * y + j);
        mem[ad] = DW'(a_v[i * y + j]);
      end
    for (int j = 0; j < y; j++)
      for (int k = 0; k < z; k++) begin
        ad = bb + AW'(j * z + k);
        mem[ad] = DW'(b_v[j * z + k]);
      end
    for (int i = 0; i < x; i++)
      for (int k = 0; k < z; k++) begin
        total = 0;
        for (int j = 0; j < y; j++) total += longint'(a_v[i * y + j]) * longint'(b_v[j * z + k]);
        ea.push_back(bc + AW'(i * z + k));
`ifdef MATMUL_SATURATE_EN
        if (total > 65535) begin
          eovf = 1;
          total = 65535;
        end
`endif
        ed.push_back(CW'(total % 65536));
      end
    nexp = x * z * (3 * y + 1) + 1;

    @(negedge clock);
    w0 = wq_addr.size();
    r0 = rd_cnt;
    dim_x = MW'(x); dim_y = MW'(y); dim_z = MW'(z);
    base_a = ba; base_b = bb; base_c = bc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, {31'b0, busy}, 1);
    while (!done && cyc < 2000) begin
      start = (dbl && (cyc == 4 || cyc == 11)) ? 1'b1 : 1'b0;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, nexp);
    chk({tag, "_err"}, {31'b0, err}, 0);
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eovf});
    chk({tag, "_reads"}, rd_cnt - r0, 2 * x * y * z);
    chk({tag, "_writes"}, wq_addr.size() - w0, x * z);
    for (int n = 0; n < x * z && (w0 + n) < wq_addr.size(); n++) begin
      chk({tag, "_waddr"}, {16'b0, wq_addr[w0 + n]}, {16'b0, ea[n]});
      chk({tag, "_wdata"}, {16'b0, wq_data[w0 + n]}, {16'b0, ed[n]});
    end
    @(negedge clock);
    chk({tag, "_done_pulse"}, {30'b0, done, busy}, 0);
  endtask

  initial begin
    int w0, r0, cyc;
    rst_r = 1'b1; start = 1'b0;
    dim_x = '0; dim_y = '0; dim_z = '0;
    base_a = '0; base_b = '0; base_c = '0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_flags", {26'b0, rd_en, wr_en, busy, done, err, ovf}, 0);
    chk("reset_addr", {rd_addr, wr_addr}, 0);
    chk("reset_wdata", {16'b0, wr_data}, 0);
    rst_r = 1'b0;

    // 2x2x2 directed case: expected C = 19,22,43,50.
    a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4;
    b_v[0] = 5; b_v[1] = 6; b_v[2] = 7; b_v[3] = 8;
    run(2, 2, 2, 16'h0000, 16'h0010, 16'h0020, 0, 0, "m222");
    if (wq_data.size() >= 4) begin
      chk("m222_c00", {16'b0, wq_data[0]}, 19);
      chk("m222_c11", {16'b0, wq_data[3]}, 50);
    end

    // 1x1x1: single product 63, done at cycle 5, two reads.
    a_v[0] = 7; b_v[0] = 9;
    run(1, 1, 1, 16'h0100, 16'h0200, 16'h0300, 0, 0, "m111");
    chk("m111_c", {16'b0, wq_data[wq_data.size() - 1]}, 63);

    // Zero dimension: immediate done with err, no memory traffic.
    @(negedge clock);
    w0 = wq_addr.size(); r0 = rd_cnt;
    dim_x = 2; dim_y = 0; dim_z = 2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("zero_done", {30'b0, done, err}, 3);
    repeat (3) @(negedge clock);
    chk("zero_err_held", {31'b0, err}, 1);
    chk("zero_no_access", {rd_cnt - r0 + (wq_addr.size() - w0)}, 0);

    // All-255 1x2x1: 130050 wraps to 0xFC02 or saturates to 0xFFFF.
    for (int n = 0; n < 16; n++) begin a_v[n] = 255; b_v[n] = 255; end
    run(1, 2, 1, 16'h0400, 16'h0500, 16'h0600, 0, 0, "ovf");
`ifdef MATMUL_SATURATE_EN
    chk("ovf_value", {16'b0, wq_data[wq_data.size() - 1]}, 32'hFFFF);
`else
    chk("ovf_value", {16'b0, wq_data[wq_data.size() - 1]}, 32'hFC02);
`endif

    // Extra start pulses while busy must change nothing.
    a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4;
    b_v[0] = 5; b_v[1] = 6; b_v[2] = 7; b_v[3] = 8;
    run(2, 2, 2, 16'h0000, 16'h0010, 16'h0020, 0, 1, "dblstart");

    // Reset after the first C write aborts the run.
    @(negedge clock);
    w0 = wq_addr.size();
    dim_x = 2; dim_y = 2; dim_z = 2;
    base_a = 16'h0000; base_b = 16'h0010; base_c = 16'h0020;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (wq_addr.size() == w0 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("rst_first_write_seen", wq_addr.size() - w0, 1);
    @(negedge clock);
    rst_r = 1'b1;
    #1;
    chk("rst_flags", {26'b0, rd_en, wr_en, busy, done, err, ovf}, 0);
    chk("rst_addr", {rd_addr, wr_addr}, 0);
    @(negedge clock);
    rst_r = 1'b0;
    w0 = wq_addr.size(); r0 = rd_cnt;
    repeat (20) @(negedge clock);
    chk("rst_quiet", {rd_cnt - r0 + (wq_addr.size() - w0)}, 0);
    chk("rst_no_done", {31'b0, done}, 0);
    run(2, 2, 2, 16'h0000, 16'h0010, 16'h0020, 0, 0, "after_rst");

    // Randomized shapes and data.
    for (int t = 0; t < 6; t++)
      run($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
          AW'($urandom_range(0, 16'h0FFF)), AW'(16'h2000 + $urandom_range(0, 16'h0FFF)),
          AW'(16'h4000 + $urandom_range(0, 16'h0FFF)), 1, 0, "rand");

    // Address wrap past 0xFFFF for A and C.
    run(2, 2, 3, 16'hFFFE, 16'h3000, 16'hFFFC, 1, 0, "wrap");

    chk("rd_wr_exclusive", conflicts, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
